iter_counter: RTL and testbench
===============================

Name: iter_counter

Overview:
- Parametrised, loadable iteration counter with a registered start/busy/done handshake.
- Sequences the bit-serial loops of the RSA datapath, such as the square-and-multiply exponent scan and the Montgomery inner loop.
- Generalises the fixed 6-bit preset down-counter with these additions:
  - configurable width and terminal value,
  - count direction selected at run time,
  - an enable for stalling,
  - a one-cycle terminal pulse,
  - optional auto-reload for back-to-back loops.

Parameters:
- WIDTH, 6: counter and load-value width in bits, 2 to 32.
- END_VAL, 1: terminal count value; must fit in WIDTH bits.
- AUTO_RELOAD, 0: 1 = on en while in DONE, restart from the last loaded value; 0 = DONE holds until the next load.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  start strobe; captures load_val and dir.
- load_val  in  WIDTH  initial count value.
- dir  in  1  count direction, sampled only on load: 0 = down, 1 = up.
- en  in  1  advance enable; 0 stalls the counter.
- count  out  WIDTH  current count value (registered).
- busy  out  1  high in state RUN.
- done  out  1  high in state DONE (level).
- tc  out  1  one-cycle pulse on each entry to DONE.

Behaviour:
- All outputs are registered. There is no combinational path from any input to any output.
- Priority order: rst > load > en.
- Reset values, applied on the edge where rst=1:
  - state = IDLE, count = 0, busy = 0, done = 0, tc = 0,
  - reload register = 0, direction register = 0 (down).
- FSM states: IDLE, RUN, DONE.
- load (in any state, including mid-RUN):
  - Captures load_val into both count and the reload register, and captures dir.
  - Next state is DONE with tc=1 if load_val == END_VAL; otherwise RUN with tc=0.
  - A mid-RUN load aborts the current loop with no tc for the aborted loop.
- IDLE:
  - en is ignored; count holds.
- RUN:
  - With en=1: count <= count-1 (dir=0) or count+1 (dir=1), modulo 2^WIDTH.
    - If the next count == END_VAL, state becomes DONE, with done=1 and tc=1 on the same edge.
  - With en=0: count and state hold. No tc is produced.
- Wrap-around:
  - Down from 0 gives 2^WIDTH-1; up from 2^WIDTH-1 gives 0.
  - The counter keeps counting through the wrap until END_VAL is reached.
  - Loop length is therefore (load_val - END_VAL) mod 2^WIDTH for down, and (END_VAL - load_val) mod 2^WIDTH for up.
- DONE:
  - count holds at END_VAL and done stays high.
  - tc is high only on the entry cycle and drops to 0 on the next edge.
  - With AUTO_RELOAD=1 and en=1:
    - count <= reload register.
    - Next state is RUN, or DONE with a fresh tc pulse if the reload value == END_VAL.
  - With AUTO_RELOAD=0: en is ignored.
- busy and done are never both 1. tc=1 implies done=1.
- Latency:
  - The first count change happens one edge after the load edge, provided en=1.
  - From a load of value V (down, END_VAL=1, en held high), done rises exactly V-1 edges after the load edge.
- rst asserted mid-RUN returns the block to the reset values on that edge. The reload register is also cleared.

Test Plan:
1. Basic down count:
   - Stimulus: WIDTH=6, END_VAL=1; load=1 with load_val=5, then en=1 continuously.
   - Response: count sequence 5,4,3,2,1; busy high for 4 cycles; done and tc rise together on the edge where count becomes 1; tc low on the next cycle; count holds at 1.
2. Stall and abort:
   - Stimulus: load 10; en pattern 1,0,0,1; then load=1 with load_val=3 while count=8.
   - Response: count sequence 10,9,9,9,8; after the reload, count sequence 3,2,1, with exactly one tc pulse in total.
3. Simultaneous events:
   - Stimulus: load=1 and en=1 on the same edge with load_val=7.
   - Response: count=7, not 6; busy=1.
   - Stimulus: rst=1 together with load=1.
   - Response: count=0, state IDLE, done=0.
4. Wrap and up count:
   - Stimulus: dir=1, load_val=62, END_VAL=1.
   - Response: count sequence 62,63,0,1; done after 3 enabled edges.
   - Stimulus: dir=0, load_val=0.
   - Response: count sequence 0,63,62,…; done after 63 enabled edges.
5. Immediate terminal:
   - Stimulus: load_val=1 (equal to END_VAL).
   - Response: done=1 and tc=1 on the load edge; busy never asserts.
6. Auto-reload:
   - Stimulus: AUTO_RELOAD=1, load 4, en held high.
   - Response: count repeats 4,3,2,1,4,3,2,1; tc pulses once every 4 cycles, each time count becomes 1.
   - Stimulus: same sequence with AUTO_RELOAD=0.
   - Response: count stays at 1 and done stays high.

Source files
------------

// File: rtl/iter_counter.sv
// Loadable iteration counter with start/busy/done handshake, used to sequence
// bit-serial loops. Count direction is chosen per load; optional auto-reload.
module iter_counter #(
  parameter int unsigned WIDTH       = 6,
  parameter int unsigned END_VAL     = 1,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  localparam logic [WIDTH-1:0] END_V = WIDTH'(END_VAL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] step_val;

  always_comb begin
    step_val = dir_q ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    dir_d    = dir_q;
    tc_d     = 1'b0;

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      dir_d    = dir;
      if (load_val == END_V) begin
        state_d = S_DONE;
        tc_d    = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (en) begin
            count_d = step_val;
            if (step_val == END_V) begin
              state_d = S_DONE;
              tc_d    = 1'b1;
            end
          end
        end
        S_DONE: begin
          // Back-to-back loops restart from the last loaded value and direction.
          if (AUTO_RELOAD && en) begin
            count_d = reload_q;
            if (reload_q == END_V) begin
              tc_d = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      dir_q    <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      dir_q    <= dir_d;
      tc_q     <= tc_d;
    end
  end

  always_comb begin
    count = count_q;
    busy  = (state_q == S_RUN);
    done  = (state_q == S_DONE);
    tc    = tc_q;
  end

endmodule

// File: tb/tb_iter_counter.sv
// Bench for iter_counter: two instances (auto-reload off/on) share stimulus and
// are compared every cycle against a remaining-steps model, plus literal checks.
module tb_iter_counter;

  localparam int W  = 6;
  localparam int EV = 1;
  localparam int M  = 64;

  logic         clk = 1'b0;
  logic         rst, load, dir, en;
  logic [W-1:0] load_val;
  logic [W-1:0] count0, count1;
  logic         busy0, done0, tc0, busy1, done1, tc1;

  iter_counter #(.WIDTH(W), .END_VAL(EV), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .dir(dir), .en(en),
    .count(count0), .busy(busy0), .done(done0), .tc(tc0)
  );

  iter_counter #(.WIDTH(W), .END_VAL(EV), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .dir(dir), .en(en),
    .count(count1), .busy(busy1), .done(done1), .tc(tc1)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: loop tracked as number of enabled steps remaining until terminal.
  int m_cnt[2], m_rem[2], m_rl[2];
  bit m_busy[2], m_done[2], m_tc[2], m_dir[2];
  bit m_valid = 1'b0;

  function automatic int modm(input int x);
    return ((x % M) + M) % M;
  endfunction

  function automatic void m_start(input int i, input int v, input bit d);
    m_cnt[i] = v;
    m_rl[i]  = v;
    m_dir[i] = d;
    m_rem[i] = d ? modm(EV - v) : modm(v - EV);
    m_done[i] = (m_rem[i] == 0);
    m_tc[i]   = (m_rem[i] == 0);
    m_busy[i] = (m_rem[i] != 0);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_cnt[i] = 0; m_rem[i] = 0; m_rl[i] = 0; m_dir[i] = 1'b0;
        m_busy[i] = 1'b0; m_done[i] = 1'b0; m_tc[i] = 1'b0;
        m_valid = 1'b1;
      end else if (load) begin
        m_start(i, int'(load_val), dir);
      end else begin
        m_tc[i] = 1'b0;
        if (m_busy[i] && en) begin
          m_cnt[i] = modm(m_cnt[i] + (m_dir[i] ? 1 : -1));
          m_rem[i] = m_rem[i] - 1;
          if (m_rem[i] == 0) begin
            m_busy[i] = 1'b0; m_done[i] = 1'b1; m_tc[i] = 1'b1;
          end
        end else if (m_done[i] && en && i == 1) begin
          m_start(i, m_rl[i], m_dir[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cmp_count0", 32'(count0), 32'(m_cnt[0]));
      chk("cmp_busy0",  32'(busy0),  32'(m_busy[0]));
      chk("cmp_done0",  32'(done0),  32'(m_done[0]));
      chk("cmp_tc0",    32'(tc0),    32'(m_tc[0]));
      chk("cmp_count1", 32'(count1), 32'(m_cnt[1]));
      chk("cmp_busy1",  32'(busy1),  32'(m_busy[1]));
      chk("cmp_done1",  32'(done1),  32'(m_done[1]));
      chk("cmp_tc1",    32'(tc1),    32'(m_tc[1]));
    end
  end

  task automatic step(input logic l, input int v, input logic d, input logic e);
    load = l; load_val = W'(v); dir = d; en = e;
    @(negedge clk);
  endtask

  int n_tc;
  int ar_seq[7] = '{3, 2, 1, 4, 3, 2, 1};

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; dir = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(count0), 0);
    chk("rst_busy",  32'(busy0),  0);
    chk("rst_done",  32'(done0),  0);
    chk("rst_tc",    32'(tc0),    0);
    rst = 1'b0;
    step(0, 9, 0, 1);
    chk("idle_ignores_en", 32'(count0), 0);

    // Basic down count 5..1
    step(1, 5, 0, 1);
    chk("t1_load", 32'(count0), 5);
    chk("t1_busy", 32'(busy0), 1);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1);
    chk("t1_not_done_yet", 32'(done0), 0);
    step(0, 0, 0, 1);
    chk("t1_end_count", 32'(count0), 1);
    chk("t1_end_tc", 32'(tc0), 1);
    step(0, 0, 0, 1);
    chk("t1_tc_drop", 32'(tc0), 0);
    chk("t1_hold", 32'(count0), 1);

    // Stall and abort
    n_tc = 0;
    step(1, 10, 0, 1); n_tc += int'(tc0);
    step(0, 0, 0, 1);  n_tc += int'(tc0);
    step(0, 0, 0, 0);  n_tc += int'(tc0);
    step(0, 0, 0, 0);  n_tc += int'(tc0);
    chk("t2_stall", 32'(count0), 9);
    step(0, 0, 0, 1);  n_tc += int'(tc0);
    chk("t2_before_abort", 32'(count0), 8);
    step(1, 3, 0, 1);  n_tc += int'(tc0);
    chk("t2_reload", 32'(count0), 3);
    step(0, 0, 0, 1);  n_tc += int'(tc0);
    step(0, 0, 0, 1);  n_tc += int'(tc0);
    step(0, 0, 0, 1);  n_tc += int'(tc0);
    chk("t2_end_count", 32'(count0), 1);
    chk("t2_tc_pulses", 32'(n_tc), 1);

    // Simultaneous events
    step(1, 7, 0, 1);
    chk("t3_load_over_en", 32'(count0), 7);
    chk("t3_busy", 32'(busy0), 1);
    rst = 1'b1;
    step(1, 20, 0, 1);
    rst = 1'b0;
    chk("t3_rst_over_load_cnt", 32'(count0), 0);
    chk("t3_rst_over_load_done", 32'(done0), 0);
    chk("t3_rst_over_load_busy", 32'(busy0), 0);

    // Up count through wrap, then down from 0
    step(1, 62, 1, 1);
    step(0, 0, 0, 1);
    chk("t4_up_63", 32'(count0), 63);
    step(0, 0, 0, 1);
    chk("t4_up_wrap", 32'(count0), 0);
    step(0, 0, 0, 1);
    chk("t4_up_done", 32'(done0), 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("t4_down_wrap", 32'(count0), 63);
    for (int k = 0; k < 61; k++) step(0, 0, 0, 1);
    chk("t4_down_62", 32'(count0), 2);
    chk("t4_down_not_done", 32'(done0), 0);
    step(0, 0, 0, 1);
    chk("t4_down_done", 32'(done0), 1);

    // Immediate terminal
    step(1, 1, 0, 1);
    chk("t5_done", 32'(done0), 1);
    chk("t5_tc", 32'(tc0), 1);
    chk("t5_busy", 32'(busy0), 0);
    step(0, 0, 0, 1);
    chk("t5_tc_drop", 32'(tc0), 0);
    chk("t5_ar_retrigger", 32'(tc1), 1);
    chk("t5_ar_busy", 32'(busy1), 0);

    // Auto-reload vs hold
    step(1, 4, 0, 1);
    chk("t6_load", 32'(count1), 4);
    n_tc = 0;
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 0, 1);
      chk($sformatf("t6_ar_seq%0d", k), 32'(count1), 32'(ar_seq[k]));
      n_tc += int'(tc1);
    end
    chk("t6_ar_tc_pulses", 32'(n_tc), 2);
    chk("t6_hold_count", 32'(count0), 1);
    chk("t6_hold_done", 32'(done0), 1);

    step(0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
